wshb_mire_slave: RTL and testbench
==================================

# wshb_mire_slave

Wishbone classic-cycle responder that serves a synthetic framebuffer (test pattern, "mire") to the display read path. It is the slave counterpart of the VGA Wishbone master: it answers sequential 32-bit pixel reads with generated 24-bit RGB values computed from the pixel address, so the display chain can be validated without SDRAM. A small register bank selects the pattern and counts served frames.

## Interface
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- LATENCY, 1, wait cycles between request acceptance and ack (≥0)
- CTRL_BASE, 32'h0100_0000, byte base address of register bank
- wshb_clk  in  1  single clock; all logic on rising edge
- wshb_rst_n  in  1  reset, synchronous, active-low
- cyc  in  1  bus cycle
- stb  in  1  strobe
- we  in  1  1 = write
- adr  in  32  byte address; adr[1:0] ignored
- dat_ms  in  32  write data
- sel  in  4  byte enables (register writes only)
- dat_sm  out  32  read data, valid while ack=1
- ack  out  1  one-cycle acknowledge

## Operation
- Pixel region: byte address < 4·HDISP·VDISP; idx = adr[.. :2], width $clog2(HDISP·VDISP). Read returns {8'h00,R,G,B}. Writes acked, ignored.
- Addresses ≥ 4·HDISP·VDISP and outside register bank: read 0, write ignored, always acked.
- Registers (offset from CTRL_BASE): +0 MODE[1:0] rw, reset 0; +4 COLOR[23:0] rw, reset 0; +8 FRAME[31:0] ro, reset 0; +C ID ro = 32'h4D495245. Writes honor sel per byte; writes to ro registers ignored.
- Patterns from (x,y): MODE 0 color bars, 8 bars of width HDISP/8 (last bar absorbs remainder): white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF/8'h00); MODE 1 checker: x[5]^y[5] ? 24'hFFFFFF : 0; MODE 2 gradient: R=x[7:0], G=y[7:0], B=(x+y)[7:0]; MODE 3 solid COLOR.
- Position cache: registers next_idx, x, y (reset 0). Request with idx == next_idx uses cached x,y (fast path). Otherwise DIVIDE: rem←idx, y←0; each cycle rem≥HDISP ⇒ rem−=HDISP, y++; else x←rem.
- After serving a pixel read: next_idx←idx+1, x++; x==HDISP−1 ⇒ x←0,y++; idx==HDISP·VDISP−1 ⇒ next_idx,x,y←0 and FRAME++ (wraps at 2^32).
- FSM: IDLE → (cyc&stb, pixel read miss) DIVIDE → WAIT; IDLE → (cyc&stb otherwise) WAIT; WAIT counts LATENCY cycles → ACK (1 cycle) → GAP (1 cycle) → IDLE. LATENCY=0 skips WAIT.
- Request latched (adr, we, dat_ms, sel) at acceptance in IDLE. Register write committed in ACK cycle.
- cyc or stb low during DIVIDE/WAIT: abort to IDLE, no ack, no cache/FRAME update.
- wshb_rst_n=0 at any edge: state IDLE, ack 0, dat_sm 0, MODE/COLOR/FRAME 0, cache 0; in-flight request dropped.

## Timing
- Reset values: ack=0, dat_sm=32'h0.
- Fast path: accepted at edge n ⇒ ack=1 during cycle n+1+LATENCY, dat_sm valid same cycle, ack low next cycle (GAP); next acceptance earliest edge n+3+LATENCY.
- Miss path adds y+1 cycles (DIVIDE) before WAIT.
- ack never high on two consecutive cycles (master edge-detects ack).
- dat_sm holds 0 outside ACK cycles.
- Pattern change via MODE write affects reads accepted after the write's ACK.

## Test plan
- Reset then sequential reads idx 0..3, MODE 0, LATENCY 1 -> each ack 2 cycles after accept, dat_sm=32'h00FFFFFF, acks separated by ≥2 cycles.
- Write MODE=2, read idx 801 (miss, HDISP=800) -> DIVIDE 2 cycles, dat_sm=32'h00010102 (x=1,y=1).
- Read all 384000 pixels sequentially -> FRAME reads 1; next read of idx 0 hits fast path; FRAME write ignored.
- Write COLOR=32'h00123456 with sel=4'b0011, MODE=3 -> pixel read returns 32'h00003456; ID read returns 32'h4D495245.
- Drop stb during WAIT, then assert wshb_rst_n=0 mid-DIVIDE -> no ack, all registers and dat_sm 0 next cycle, following read of idx 0 returns MODE 0 white.
- Read unmapped address 32'h0080_0000 -> ack with dat_sm=0; write there -> ack, no register change.

Source files
------------

// File: rtl/wshb_mire_slave.sv
// Wishbone classic slave that serves a synthetic test-pattern framebuffer.
// Pixel reads return {8'h00,R,G,B}; a small register bank selects the pattern.
module wshb_mire_slave #(
  parameter int          HDISP     = 800,
  parameter int          VDISP     = 480,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] CTRL_BASE = 32'h0100_0000
) (
  input  logic        wshb_clk,
  input  logic        wshb_rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat_ms,
  input  logic [3:0]  sel,
  output logic [31:0] dat_sm,
  output logic        ack
);

  localparam int          NPIX    = HDISP * VDISP;
  localparam int          IW      = $clog2(NPIX);
  localparam int          XW      = $clog2(HDISP);
  localparam int          YW      = $clog2(VDISP);
  localparam int          BAR_W   = HDISP / 8;
  localparam logic [31:0] PIX_END = 32'(4 * NPIX);
  localparam logic [31:0] ID_WORD = 32'h4D49_5245;

  typedef enum logic [2:0] {S_IDLE, S_DIVIDE, S_WAIT, S_ACK, S_GAP} state_t;
  localparam state_t AFTER_SETUP = (LATENCY == 0) ? S_ACK : S_WAIT;

  state_t state, state_nxt;

  logic          req;
  logic          req_we;
  logic [31:0]   req_adr;
  logic [23:0]   req_dat;
  logic [2:0]    req_sel;
  logic [IW-1:0] idx_in, req_idx;
  logic          miss_in, req_pix, req_reg, div_done, wait_done;
  logic [IW-1:0] rem;
  logic [XW-1:0] cur_x, x_q;
  logic [YW-1:0] cur_y, y_q;
  logic [IW-1:0] next_idx;
  logic [15:0]   wait_cnt;
  logic [1:0]    mode;
  logic [23:0]   color;
  logic [31:0]   frame;
  logic [23:0]   pix;
  logic [31:0]   rdata;
  logic          unused_ok;

  assign req       = cyc & stb;
  assign idx_in    = adr[IW+1:2];
  assign miss_in   = (adr < PIX_END) && !we && (idx_in != next_idx);
  assign req_idx   = req_adr[IW+1:2];
  assign req_pix   = req_adr < PIX_END;
  assign req_reg   = req_adr[31:4] == CTRL_BASE[31:4];
  assign div_done  = rem < IW'(HDISP);
  assign wait_done = wait_cnt == 16'(LATENCY - 1);
  assign unused_ok = ^{adr[1:0], dat_ms[31:24], sel[3]};

  always_ff @(posedge wshb_clk) begin
    if (!wshb_rst_n) state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_IDLE:   if (req) state_nxt = miss_in ? S_DIVIDE : AFTER_SETUP;
      S_DIVIDE: if (!req) state_nxt = S_IDLE;
                else if (div_done) state_nxt = AFTER_SETUP;
      S_WAIT:   if (!req) state_nxt = S_IDLE;
                else if (wait_done) state_nxt = S_ACK;
      S_ACK:    state_nxt = S_GAP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Request latch, divider and wait counter: every value is rewritten before use.
  // NOTE: these datapath registers are deliberately not reset; only control state and visible registers are.
  always_ff @(posedge wshb_clk) begin
    wait_cnt <= (state == S_WAIT) ? wait_cnt + 16'd1 : '0;
    if (state == S_IDLE && req) begin
      req_we  <= we;
      req_adr <= adr;
      req_dat <= dat_ms[23:0];
      req_sel <= sel[2:0];
      if (miss_in) begin
        rem   <= idx_in;
        cur_y <= '0;
      end else begin
        cur_x <= x_q;
        cur_y <= y_q;
      end
    end
    if (state == S_DIVIDE) begin
      if (!div_done) begin
        rem   <= rem - IW'(HDISP);
        cur_y <= cur_y + 1'b1;
      end else begin
        cur_x <= rem[XW-1:0];
      end
    end
  end

  // Register writes and cache/FRAME updates commit only in the ACK cycle, so aborts leave them untouched.
  always_ff @(posedge wshb_clk) begin
    if (!wshb_rst_n) begin
      mode     <= '0;
      color    <= '0;
      frame    <= '0;
      next_idx <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (state == S_ACK) begin
      if (req_we && req_reg) begin
        if (req_adr[3:2] == 2'd0 && req_sel[0]) mode <= req_dat[1:0];
        if (req_adr[3:2] == 2'd1) begin
          for (int b = 0; b < 3; b++)
            if (req_sel[b]) color[8*b +: 8] <= req_dat[8*b +: 8];
        end
      end else if (!req_we && req_pix) begin
        if (req_idx == IW'(NPIX - 1)) begin
          next_idx <= '0;
          x_q      <= '0;
          y_q      <= '0;
          frame    <= frame + 32'd1;
        end else begin
          next_idx <= req_idx + 1'b1;
          if (cur_x == XW'(HDISP - 1)) begin
            x_q <= '0;
            y_q <= cur_y + 1'b1;
          end else begin
            x_q <= cur_x + 1'b1;
            y_q <= cur_y;
          end
        end
      end
    end
  end

  always_comb begin
    logic [15:0] xe, ye;
    logic [2:0]  bar;
    xe  = 16'(cur_x);
    ye  = 16'(cur_y);
    bar = '0;
    for (int b = 1; b < 8; b++)
      if (xe >= 16'(b * BAR_W)) bar = 3'(b);
    // Bar order white..black maps to R=~bar[1], G=~bar[2], B=~bar[0].
    case (mode)
      2'd0:    pix = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
      2'd1:    pix = (xe[5] ^ ye[5]) ? 24'hFF_FFFF : 24'h00_0000;
      2'd2:    pix = {xe[7:0], ye[7:0], 8'(xe + ye)};
      default: pix = color;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (!req_we) begin
      if (req_pix) begin
        rdata = {8'h00, pix};
      end else if (req_reg) begin
        case (req_adr[3:2])
          2'd0:    rdata = {30'd0, mode};
          2'd1:    rdata = {8'h00, color};
          2'd2:    rdata = frame;
          default: rdata = ID_WORD;
        endcase
      end
    end
    ack    = (state == S_ACK);
    dat_sm = ack ? rdata : 32'h0;
  end

endmodule

// File: tb/tb_wshb_mire_slave.sv
// Self-checking bench for wshb_mire_slave on a reduced 84x6 frame so a full
// frame fits in a short run; expectations come from an arithmetic reference model.
module tb_wshb_mire_slave;

  localparam int          H    = 84;
  localparam int          V    = 6;
  localparam int          LAT  = 1;
  localparam int          NPIX = H * V;
  localparam logic [31:0] CB   = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat_ms = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_sm;
  logic        ack;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_mode  = 0;
  logic [23:0] m_color = '0;
  logic [31:0] m_frame = '0;
  int          m_next  = 0;

  wshb_mire_slave #(.HDISP(H), .VDISP(V), .LATENCY(LAT), .CTRL_BASE(CB)) dut (
    .wshb_clk(clk), .wshb_rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we),
    .adr(adr), .dat_ms(dat_ms), .sel(sel), .dat_sm(dat_sm), .ack(ack)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pattern(input int x, input int y);
    logic [23:0] bars [8];
    int bar;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    case (m_mode)
      0: begin
        bar = x / (H / 8);
        if (bar > 7) bar = 7;
        return bars[bar];
      end
      1:       return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      2:       return 24'(((x & 255) << 16) | ((y & 255) << 8) | ((x + y) & 255));
      default: return m_color;
    endcase
  endfunction

  // One classic cycle; called #1 after a posedge with the DUT idle. n counts edges until ack.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int n);
    adr = a; we = w; dat_ms = d; sel = s; cyc = 1'b1; stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 100);
    rd = dat_sm;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("gap_ack", {31'd0, ack}, 32'd0);
    check("gap_dat", dat_sm, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic pix_read(input int idx, input string tag);
    logic [31:0] rd;
    int n, x, y, exp_n;
    x = idx % H;
    y = idx / H;
    exp_n = 1 + LAT + ((idx != m_next) ? y + 1 : 0);
    xfer(32'(idx * 4), 1'b0, 32'd0, 4'h0, rd, n);
    check({tag, "_data"}, rd, {8'h00, pattern(x, y)});
    check({tag, "_lat"}, 32'(n), 32'(exp_n));
    m_next = (idx + 1) % NPIX;
    if (idx == NPIX - 1) m_frame++;
  endtask

  task automatic reg_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    int n;
    xfer(CB + 32'(off), 1'b1, d, s, rd, n);
    check("wr_lat", 32'(n), 32'(1 + LAT));
    if (off == 4'h0 && s[0]) m_mode = int'(d[1:0]);
    if (off == 4'h4)
      for (int b = 0; b < 3; b++)
        if (s[b]) m_color[8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic reg_read(input logic [3:0] off, input string tag);
    logic [31:0] rd, exp;
    int n;
    case (off)
      4'h0:    exp = 32'(m_mode);
      4'h4:    exp = {8'h00, m_color};
      4'h8:    exp = m_frame;
      default: exp = 32'h4D495245;
    endcase
    xfer(CB + 32'(off), 1'b0, 32'd0, 4'h0, rd, n);
    check({tag, "_data"}, rd, exp);
    check({tag, "_lat"}, 32'(n), 32'(1 + LAT));
  endtask

  initial begin
    logic [31:0] rd;
    int n, r, idx;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dat_sm, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Sequential reads in MODE 0: white bar
    for (int i = 0; i < 4; i++) pix_read(i, "seq");

    // MODE 2 then a miss at x=1,y=1
    reg_write(4'h0, 32'd2, 4'hF);
    pix_read(H + 1, "miss");

    // Randomized mix of register and pixel traffic
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1: reg_write(4'h0, $urandom, 4'($urandom));
        2:    reg_write(4'h4, $urandom, 4'($urandom));
        3:    reg_read(4'(4 * $urandom_range(0, 3)), "rnd_reg");
        4, 5, 6: pix_read(m_next, "rnd_hit");
        7, 8: pix_read(int'($urandom_range(0, NPIX - 1)), "rnd_pix");
        default: pix_read(NPIX - 1, "rnd_last");
      endcase
    end

    // Full frame in a random mode
    reg_write(4'h0, $urandom, 4'h1);
    for (int i = 0; i < NPIX; i++) pix_read(i, "frame");
    reg_read(4'h8, "frame_cnt");
    pix_read(0, "wrap_hit");
    reg_write(4'h8, 32'hDEAD_BEEF, 4'hF);
    reg_read(4'h8, "frame_ro");

    // Drop stb while waiting: no ack, cache untouched
    pix_read(10, "pre_abort");
    idx = m_next;
    adr = 32'(idx * 4); we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    check("abort_wait_ack", {31'd0, ack}, 32'd0);
    stb = 1'b0;
    @(posedge clk); #1;
    check("abort_ack", {31'd0, ack}, 32'd0);
    cyc = 1'b0;
    @(posedge clk); #1;
    pix_read(idx, "post_abort");

    // Reset in the middle of a long divide (y=5)
    adr = 32'((5 * H + 3) * 4); we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_div_ack", {31'd0, ack}, 32'd0);
    check("rst_div_dat", dat_sm, 32'd0);
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0;
    m_mode = 0; m_color = '0; m_frame = '0; m_next = 0;
    @(posedge clk); #1;
    reg_read(4'h0, "rst_mode");
    reg_read(4'h4, "rst_color");
    reg_read(4'h8, "rst_frame");
    pix_read(0, "rst_white");

    // Byte-enabled COLOR write, solid mode, ID
    reg_write(4'h4, 32'h0012_3456, 4'b0011);
    reg_write(4'h0, 32'd3, 4'hF);
    pix_read(200, "solid");
    check("color_val", {8'h00, m_color}, 32'h0000_3456);
    reg_read(4'hC, "id");
    reg_write(4'hC, 32'h0, 4'hF);
    reg_read(4'hC, "id_ro");

    // Unmapped and boundary addresses, ignored writes
    xfer(32'h0080_0000, 1'b0, 32'd0, 4'h0, rd, n);
    check("unmap_rd", rd, 32'd0);
    check("unmap_lat", 32'(n), 32'(1 + LAT));
    xfer(32'(4 * NPIX), 1'b0, 32'd0, 4'h0, rd, n);
    check("pix_end_rd", rd, 32'd0);
    xfer(32'h0080_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, n);
    check("unmap_wr_lat", 32'(n), 32'(1 + LAT));
    reg_read(4'h0, "unmap_mode");
    reg_read(4'h4, "unmap_color");
    xfer(32'(5 * 4), 1'b1, 32'h00AB_CDEF, 4'hF, rd, n);
    check("pix_wr_lat", 32'(n), 32'(1 + LAT));
    pix_read(5, "pix_wr_ign");
    pix_read(NPIX - 1, "last_pix");
    reg_read(4'h8, "last_frame");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
